// File: rtl/sync_fifo_param_if.sv
// Purpose: groups the request, data and status signals of sync_fifo_param into one bundle.
// Latency: none; this file only declares wires and the two directions of use.
// Backpressure: the full/empty status travels back through this bundle; the FIFO drops requests that are blocked.
// Ports: master = producer/consumer side (drives w_en, w_data, r_en, err_clr);
//        slave  = FIFO side (drives r_data, r_valid, count and all status flags).
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, w_data, r_en, err_clr,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, w_data, r_en, err_clr,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Purpose: parametrised single-clock FIFO with a registered occupancy count, almost-full/almost-empty
//          thresholds, sticky overflow/underflow flags and a selectable standard or FWFT read port.
// Latency: the write is visible 1 cycle later. In standard mode read data arrives 1 cycle after r_en.
//          In FWFT mode the head word shows continuously.
// Backpressure: a write while full and a read while empty are dropped. The drop sets a sticky error flag.
// Ports: clk, reset (synchronous, active-high); bus (slave modport) carries w_en/w_data/r_en/err_clr in
//        and r_data/r_valid/full/empty/almost_full/almost_empty/count/overflow/underflow out.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    sync_fifo_param_if.slave bus
);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = CW'(1);

    // Each pointer has one extra MSB that acts as a wrap bit. Occupancy comes from the
    // separate count register, so the wrap bit only lets the pointers roll over cleanly.
    logic [ADDR_WIDTH:0] wp_q, wp_d;
    logic [ADDR_WIDTH:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic full, empty;
    logic wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] head;

    // Storage array. Its contents are never reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    // The flags are taken from the count before this edge. A read in the same cycle cannot
    // make room for a write into a full FIFO, and a same-cycle write cannot feed a read from
    // an empty one.
    assign wr_acc = bus.w_en && !full;
    assign rd_acc = bus.r_en && !empty;
    assign head   = mem[rp_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wp_d = wp_q + ONE_C;
        end
        if (rd_acc) begin
            rp_d = rp_q + ONE_C;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // When a new error and err_clr arrive in the same cycle, the error wins so it is not lost.
        if (bus.w_en && full) begin
            overflow_d = 1'b1;
        end else if (bus.err_clr) begin
            overflow_d = 1'b0;
        end

        if (bus.r_en && empty) begin
            underflow_d = 1'b1;
        end else if (bus.err_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Reset blocks the write so that no data lands during the reset cycle.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wp_q[ADDR_WIDTH-1:0]] <= bus.w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is always on the output, and r_en only acknowledges it.
            assign bus.r_data  = head;
            assign bus.r_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
            logic                  r_valid_q, r_valid_d;

            always_comb begin
                r_data_d  = r_data_q;
                r_valid_d = 1'b0;
                if (rd_acc) begin
                    r_data_d  = head;
                    r_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_data_q  <= r_data_d;
                    r_valid_q <= r_valid_d;
                end
            end

            assign bus.r_data  = r_data_q;
            assign bus.r_valid = r_valid_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation buffer for the pipelined CPU, replacing hand-wired RAM + pointer logic with one self-contained block. Provides generic width/depth, occupancy count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. Used between pipeline stages sharing one clock domain.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (legal 1..DEPTH)
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (legal 0..DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- w_en  in  1  write request
- w_data  in  DATA_WIDTH  write word
- r_en  in  1  read request (FWFT: pop/acknowledge of head word)
- err_clr  in  1  clears overflow/underflow
- r_data  out  DATA_WIDTH  read word
- r_valid  out  1  r_data holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_WIDTH+1  current occupancy 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write and read pointers are ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address memory, MSB is wrap bit. Pointers wrap naturally from 2*DEPTH-1 to 0.
- Write accepted iff w_en && !full: mem[wp] <= w_data, wp increments.
- Read accepted iff r_en && !empty: rp increments.
- count is a register: +1 on write-only, -1 on read-only, unchanged on both or neither; never leaves 0..DEPTH.
- full/empty/almost_* decoded combinationally from registered count; reflect state after the last edge.
- Simultaneous write+read: both accepted when neither flag blocks. When full, write rejected even if a read is accepted same cycle; when empty, read rejected even if write accepted.
- Standard mode (FWFT=0): on accepted read, r_data <= mem[rp] and r_valid <= 1 next edge; otherwise r_valid <= 0, r_data holds last value.
- FWFT mode (FWFT=1): r_data = mem[rp] continuously, r_valid = !empty; r_en pops the head; r_data undefined when empty.
- overflow <= 1 on w_en && full; underflow <= 1 on r_en && empty; both cleared only by err_clr or reset. Set has priority over err_clr in the same cycle.
- Memory contents not reset.

## Timing
- Reset (sync, dominates all inputs in that cycle): wp=rp=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, r_data=0, r_valid=0, overflow=0, underflow=0. Operation resumes the cycle after reset deasserts; reset mid-transfer discards all contents.
- Write-to-empty-deassert latency: 1 cycle (empty low after the edge sampling the write).
- Standard read latency: data valid 1 cycle after the r_en edge. FWFT: head visible 1 cycle after first write into an empty FIFO.
- Read of a word written same cycle is impossible (empty blocks); no write-through bypass.
- Flags and count change only on clk rising edges.

## Test plan
- DATA_WIDTH=8, ADDR_WIDTH=2, FWFT=0: reset, write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1 after 3rd write (AF_THRESH=3); read 4 times -> r_data 0x11..0x44 each one cycle after r_en, r_valid pulses, empty=1 at end.
- Full FIFO, w_en=1 with 0x55 -> write dropped, overflow=1 and sticky; later read returns 0x11 not 0x55; err_clr -> overflow=0.
- Empty FIFO, r_en=1 -> underflow=1, r_valid=0, count stays 0; r_en+err_clr same cycle -> underflow stays 1.
- Count=2, simultaneous w_en+r_en for 10 cycles with incrementing data -> count stays 2, pointers wrap past 7, output order exact.
- FWFT=1: write 0xA5 into empty -> next cycle r_valid=1, r_data=0xA5 without r_en; r_en -> empty=1, r_valid=0.
- Fill to 3, assert reset together with w_en -> next cycle count=0, empty=1, all flags at reset values, no write occurred.
